load_part_word_unit: RTL

// - Load-side counterpart of the store partial-word formatter: issues data-memory reads for LW/LH/LB/LHU/LBU.
// - Waits on a multi-cycle memory handshake, then extracts and sign/zero-extends the addressed lane.
// - Sits between the M stage and the W-stage register; stalls the pipeline while a load is outstanding.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/load_part_word_unit_if.sv | 36 +++
 rtl/lpart_extract.sv | 36 +++
 rtl/load_part_word_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared load-unit types: load source encoding, FSM states, legality helpers
//
// Contents:
//   XLEN                         data/address width of the load path
//   load_src_t                   LoadSrcM encoding: [1:0] size (00=W, 01=B, 10=H), [2]=unsigned
//   lsu_state_t                  load FSM states
//   src_legal(src)               1 for the five defined load encodings
//   src_misaligned(src, offset)  1 when the byte offset does not suit the access size
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LW  = 3'b000,
    LB  = 3'b001,
    LH  = 3'b010,
    LBU = 3'b101,
    LHU = 3'b110
  } load_src_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Unsigned word (3'b100) and the unused size code 2'b11 have no meaning.
  function automatic logic src_legal(input logic [2:0] src);
    logic ok;
    case (src)
      LW, LB, LH, LBU, LHU: ok = 1'b1;
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Bytes are always aligned; halves need offset[0]=0; words need offset=0.
  function automatic logic src_misaligned(input logic [2:0] src, input logic [1:0] offset);
    return ((src[1:0] == 2'b10) && offset[0]) ||
           ((src[1:0] == 2'b00) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/load_part_word_unit_if.sv
// rtl/load_part_word_unit_if.sv - data-memory read request/response bus
//
// Signals:
//   DMemReqValid  master->slave  read request valid
//   DMemAddr      master->slave  word-aligned read address
//   DMemReqReady  slave->master  memory accepts the request
//   DMemRValid    slave->master  read data valid
//   DMemRData     slave->master  full read word
// Modports: master (load unit), slave (memory).
interface load_part_word_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  DMemReqValid;
  logic [DATA_WIDTH-1:0] DMemAddr;
  logic                  DMemReqReady;
  logic                  DMemRValid;
  logic [DATA_WIDTH-1:0] DMemRData;

  modport master (
    output DMemReqValid,
    output DMemAddr,
    input  DMemReqReady,
    input  DMemRValid,
    input  DMemRData
  );

  modport slave (
    input  DMemReqValid,
    input  DMemAddr,
    output DMemReqReady,
    output DMemRValid,
    output DMemRData
  );

endinterface

// File: rtl/lpart_extract.sv
// rtl/lpart_extract.sv - combinational lane select and sign/zero extension of a loaded word
//
// Ports:
//   load_src  in   load_src_t        access size and signedness
//   offset    in   2                 byte offset within the word
//   word      in   DATA_WIDTH        full memory word
//   data      out  DATA_WIDTH        extended result
// Shared with the cache bypass path, so it carries no state.
module lpart_extract
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  load_src_t             load_src,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        is_unsigned;

  assign is_unsigned = load_src[2];

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (load_src[1:0])
      2'b01:   data = {{(DATA_WIDTH-8){~is_unsigned & lane_b[7]}}, lane_b};
      2'b10:   data = {{(DATA_WIDTH-16){~is_unsigned & lane_h[15]}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_part_word_unit.sv
// rtl/load_part_word_unit.sv - partial-word load unit: memory read handshake, lane extract, pipeline stall
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   MemReadM      load issued (sampled in IDLE only)
//   LoadSrcM      load source encoding (see riscv_pkg::load_src_t)
//   ALUResultM    byte address
//   dmem          load_part_word_unit_if.master: DMemReqValid/DMemAddr out, DMemReqReady/DMemRValid/DMemRData in
//   StallLoadM    freeze the pipeline front while a load is outstanding
//   ReadDataW     extended load result, valid with LoadValidW
//   LoadValidW    1-cycle result pulse
//   MisalignW     1-cycle misaligned-address pulse, no request issued
//   DMemErrW      1-cycle illegal-encoding or timeout pulse
module load_part_word_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     MemReadM,
  input  logic [2:0]               LoadSrcM,
  input  logic [DATA_WIDTH-1:0]    ALUResultM,
  load_part_word_unit_if.master    dmem,
  output logic                     StallLoadM,
  output logic [DATA_WIDTH-1:0]    ReadDataW,
  output logic                     LoadValidW,
  output logic                     MisalignW,
  output logic                     DMemErrW
);

  localparam int TW = $clog2(TIMEOUT + 1);

  lsu_state_t            state;
  load_src_t             src_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [TW-1:0]         timer;
  logic                  accept;
  logic [DATA_WIDTH-1:0] lane_data;

  // A legal, aligned load seen in IDLE stalls in that very cycle so the
  // front of the pipeline does not advance past it.
  assign accept = (state == IDLE) && MemReadM && src_legal(LoadSrcM) &&
                  !src_misaligned(LoadSrcM, ALUResultM[1:0]);

  assign StallLoadM        = accept || (state == REQ) || (state == WAIT);
  assign dmem.DMemReqValid = (state == REQ);
  assign dmem.DMemAddr     = addr_q;

  // Extract straight from the bus word so ReadDataW is loaded on the RESP entry edge.
  lpart_extract #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extract (
    .load_src(src_q),
    .offset  (off_q),
    .word    (dmem.DMemRData),
    .data    (lane_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_q      <= LW;
      off_q      <= 2'b00;
      addr_q     <= '0;
      timer      <= '0;
      ReadDataW  <= '0;
      LoadValidW <= 1'b0;
      MisalignW  <= 1'b0;
      DMemErrW   <= 1'b0;
    end else begin
      LoadValidW <= 1'b0;
      MisalignW  <= 1'b0;
      DMemErrW   <= 1'b0;
      case (state)
        IDLE: begin
          if (MemReadM) begin
            src_q <= load_src_t'(LoadSrcM);
            off_q <= ALUResultM[1:0];
            if (!src_legal(LoadSrcM)) begin
              DMemErrW <= 1'b1;
            end else if (src_misaligned(LoadSrcM, ALUResultM[1:0])) begin
              MisalignW <= 1'b1;
            end else begin
              addr_q <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
              state  <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem.DMemReqReady) begin
            if (dmem.DMemRValid) begin
              ReadDataW  <= lane_data;
              LoadValidW <= 1'b1;
              state      <= RESP;
            end else begin
              timer <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem.DMemRValid) begin
            ReadDataW  <= lane_data;
            LoadValidW <= 1'b1;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // This was the TIMEOUT-th empty wait cycle.
            DMemErrW <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          ReadDataW <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
